cycle_count_display: RTL and testbench
======================================

// Module: cycle_count_display
// PURPOSE
//  Consumes the 32-bit sort-cycle count from the cycle counter and shows it in decimal on the board's 8-digit 7-segment display.
//  Sequential double-dabble converts binary to BCD (one bit per clk); a free-running scan multiplexes the digits.
//  Sits directly downstream of the cycle counter, in the board top level beside the LED outputs.
// PARAMETERS
//  REFRESH_BITS  17  scan counter width; each digit dwells 2^(REFRESH_BITS-3) clk cycles
//  BLANK_LZ      1   1 = blank leading zeros (digit 0 always lit); 0 = show all 8 digits
// PORTS
//  clk        in   1   system clock; the block's only clock
//  rst        in   1   asynchronous, active-high reset
//  count_in   in   32  unsigned binary cycle count
//  load       in   1   request a conversion of count_in; sampled on the clk edge
//  busy       out  1   conversion in progress; load is ignored while high
//  bcd_valid  out  1   one-cycle pulse when the display register is updated
//  overflow   out  1   the last converted value was > 99_999_999
//  seg_n      out  7   segments {g,f,e,d,c,b,a}, active-low, registered
//  an_n       out  8   digit enables, active-low one-hot, registered; bit 0 = units
//  dp_n       out  1   decimal point; tied to 1 (off)
// BEHAVIOUR
//  Reset (async): FSM=IDLE, busy=0, bcd_valid=0, overflow=0, display reg=0, scan cnt=0.
//   First outputs after reset: an_n=8'hFE, seg_n=7'h40 ("0"). Reset mid-conversion aborts with no bcd_valid pulse.
//  FSM IDLE -> SHIFT -> PUBLISH -> IDLE:
//   IDLE: load=1 at edge N captures count_in into a 32b shift reg, clears the 40b BCD scratch, sets iter=0 and busy=1.
//   SHIFT: edges N+1..N+32. Per edge, add 3 to each scratch nibble >=5, then shift {scratch,bin} left by 1.
//   PUBLISH: edge N+33 copies scratch[31:0] to the display reg, sets overflow=|scratch[39:32],
//    pulses bcd_valid for one cycle and drops busy. Fixed latency: 33 edges from load to display update.
//  load while busy (including PUBLISH) is dropped, not queued. count_in changing mid-conversion has no effect.
//  The display reg holds the previous value throughout a conversion, so there is no flicker.
//  Scan: scan cnt wraps freely at 2^REFRESH_BITS. Digit index k = cnt[MSB-:3], so k wraps 7 -> 0.
//   an_n = ~(1<<k), seg_n = pattern(k). Both are registered, one cycle after the cnt change; never two digits low.
//  Pattern, with overflow taking priority over blanking:
//   overflow=1                                  -> 7'h3F (dash) on all digits
//   BLANK_LZ and k!=0 and digits k..7 all zero  -> 7'h7F (blank)
//   else decode 0-9: 40,79,24,30,19,12,02,78,00,10 (hex)
//  A nibble >9 cannot occur. The decoder maps it to 7'h7F as a defensive default.
// STRUCTURE
//  Shared package: FSM state enum (IDLE/SHIFT/PUBLISH), SEG_BLANK, SEG_DASH, digit-pattern constants, NUM_DIGITS=8.
//  One sub-module: seg7_decode, combinational nibble -> active-low pattern, used once on the selected digit.
//  The top module holds the FSM, the 6-bit iteration counter, the shift/scratch regs, the display reg and the scan counter.
// TESTING
//  Use REFRESH_BITS=6 in simulation.
//  1. Assert rst, release -> busy=0, bcd_valid=0, an_n=8'hFE, seg_n=7'h40; only digit 0 lit across a full scan.
//  2. load with count_in=32'd1234 -> bcd_valid exactly 33 edges later.
//     Digits 3..0 show 79,24,30,19; digits 7..4 show 7F; overflow=0.
//  3. count_in=32'd99_999_999 -> all digits 7'h10, overflow=0.
//     Then 32'd100_000_000 and 32'hFFFF_FFFF -> overflow=1, all digits 7'h3F.
//  4. load count_in=5, then load count_in=7 ten cycles later -> one bcd_valid pulse; display shows 5; busy high for exactly 33 cycles.
//  5. Display 42, load 900, assert rst at the 16th SHIFT edge -> no bcd_valid pulse; display=0, busy=0.
//     A subsequent load of 900 converts correctly.
//  6. BLANK_LZ=0 with count_in=7 -> digits 7..1 show 7'h40, digit 0 shows 7'h78.
//     Check an_n stays one-hot-low on every cycle.

Source files
------------

// File: rtl/cycle_count_display_pkg.sv
// Shared types and constants for the cycle-count 7-segment display block.
package cycle_count_display_pkg;

    localparam int NUM_DIGITS = 8;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/cycle_count_display_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern.
module seg7_decode
    import cycle_count_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    // Decode one BCD digit; codes above 9 show blank.
    always_comb begin
        case (digit)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/cycle_count_display.sv
// Converts a 32-bit cycle count to BCD with a sequential double-dabble
// (one bit per clock) and scans it onto an 8-digit 7-segment display.
module cycle_count_display
    import cycle_count_display_pkg::*;
#(
    parameter int REFRESH_BITS = 17,
    parameter int BLANK_LZ     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] count_in,
    input  logic        load,
    output logic        busy,
    output logic        bcd_valid,
    output logic        overflow,
    output logic [6:0]  seg_n,
    output logic [7:0]  an_n,
    output logic        dp_n
);

    state_t             state;
    logic [5:0]         iter;
    logic [31:0]        bin_sr;
    logic [39:0]        scratch;
    logic [39:0]        scratch_adj;
    logic [31:0]        display_reg;
    logic [REFRESH_BITS-1:0] scan_cnt;

    logic [2:0]         digit_idx;
    logic [3:0]         sel_nibble;
    logic               upper_zero;
    logic [6:0]         dec_seg;
    logic [6:0]         next_seg;

    assign dp_n = 1'b1;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        scratch_adj = scratch;
        for (int i = 0; i < 10; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Conversion sequencer: capture, 32 shift steps, then publish to the display.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the datapath registers are reset as well, so a reset mid-conversion leaves nothing stale.
        if (rst) begin
            state       <= IDLE;
            iter        <= '0;
            bin_sr      <= '0;
            scratch     <= '0;
            display_reg <= '0;
            busy        <= 1'b0;
            bcd_valid   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr  <= count_in;
                        scratch <= '0;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scratch, bin_sr} <= {scratch_adj[38:0], bin_sr, 1'b0};
                    iter <= iter + 6'd1;
                    if (iter == 6'd31)
                        state <= PUBLISH;
                end
                PUBLISH: begin
                    display_reg <= scratch[31:0];
                    overflow    <= |scratch[39:32];
                    bcd_valid   <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select the digit currently being scanned and decide what it shows.
    assign digit_idx = scan_cnt[REFRESH_BITS-1 -: 3];

    always_comb begin
        sel_nibble = display_reg[{digit_idx, 2'b00} +: 4];
        upper_zero = ((display_reg >> {digit_idx, 2'b00}) == 32'd0);
    end

    seg7_decode u_decode (
        .digit (sel_nibble),
        .seg_n (dec_seg)
    );

    // Overflow dashes win over leading-zero blanking; digit 0 is never blanked.
    always_comb begin
        if (overflow)
            next_seg = SEG_DASH;
        else if ((BLANK_LZ != 0) && (digit_idx != 3'd0) && upper_zero)
            next_seg = SEG_BLANK;
        else
            next_seg = dec_seg;
    end

    // Free-running scan counter with registered anode and segment drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            an_n     <= 8'hFE;
            seg_n    <= SEG_0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            an_n     <= ~(8'd1 << digit_idx);
            seg_n    <= next_seg;
        end
    end

endmodule

// File: tb/tb_cycle_count_display.sv
// Self-checking bench for cycle_count_display: one instance with leading-zero
// blanking and one without, driven from the same stimulus.
module tb_cycle_count_display;

    localparam int RB       = 6;
    localparam int SCAN_LEN = (1 << RB) + 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] count_in;

    logic        busy, bcd_valid, overflow, dp_n;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic        busy0, bcd_valid0, overflow0, dp_n0;
    logic [6:0]  seg_n0;
    logic [7:0]  an_n0;

    int total = 0;
    int bad   = 0;

    logic [6:0] seen  [8];
    logic [6:0] seen0 [8];

    typedef struct {
        logic [31:0] value;
        logic        ovf;
        logic [55:0] segs;   // BLANK_LZ=1, digit 7 in the top 7 bits
        logic [55:0] segs0;  // BLANK_LZ=0
    } vec_t;

    vec_t vecs [8];

    cycle_count_display #(.REFRESH_BITS(RB), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .load(load),
        .busy(busy), .bcd_valid(bcd_valid), .overflow(overflow),
        .seg_n(seg_n), .an_n(an_n), .dp_n(dp_n)
    );

    cycle_count_display #(.REFRESH_BITS(RB), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst(rst), .count_in(count_in), .load(load),
        .busy(busy0), .bcd_valid(bcd_valid0), .overflow(overflow0),
        .seg_n(seg_n0), .an_n(an_n0), .dp_n(dp_n0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits by division, then the display rules.
    function automatic logic [6:0] pat(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    function automatic logic [55:0] model_segs(input longint unsigned v, input bit blank);
        logic [55:0]     r;
        longint unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < 8; k++) begin
            if (v > 64'd99_999_999)
                r[7*k +: 7] = 7'h3F;
            else if (blank && k != 0 && v < p)
                r[7*k +: 7] = 7'h7F;
            else
                r[7*k +: 7] = pat(int'((v / p) % 10));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [55:0] pack_seen(input bit which0);
        logic [55:0] r;
        for (int k = 0; k < 8; k++)
            r[7*k +: 7] = which0 ? seen0[k] : seen[k];
        return r;
    endfunction

    // Watch a full scan on both instances, recording each digit and checking one-hot anodes.
    task automatic scan_capture(input string tag);
        bit oh  = 1'b1;
        bit oh0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            seen[k]  = 'x;
            seen0[k] = 'x;
        end
        repeat (SCAN_LEN) begin
            @(negedge clk);
            if ($countones(~an_n) != 1) oh = 1'b0;
            else for (int k = 0; k < 8; k++) if (an_n[k] == 1'b0) seen[k] = seg_n;
            if ($countones(~an_n0) != 1) oh0 = 1'b0;
            else for (int k = 0; k < 8; k++) if (an_n0[k] == 1'b0) seen0[k] = seg_n0;
        end
        check({tag, "_onehot"}, 64'(oh), 64'd1);
        check({tag, "_onehot0"}, 64'(oh0), 64'd1);
    endtask

    task automatic check_display(input longint unsigned v, input string tag);
        scan_capture(tag);
        check({tag, "_segs"},  64'(pack_seen(1'b0)), 64'(model_segs(v, 1'b1)));
        check({tag, "_segs0"}, 64'(pack_seen(1'b1)), 64'(model_segs(v, 1'b0)));
    endtask

    // One load, then verify latency, busy length, overflow and pulse width.
    task automatic do_convert(input logic [31:0] v, input string tag);
        int lat;
        int busy_cyc;
        @(negedge clk);
        count_in = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        count_in = $urandom;
        lat      = 0;
        busy_cyc = 0;
        while (!bcd_valid && lat < 60) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_len"}, 64'(busy_cyc), 64'd33);
        check({tag, "_valid0"}, 64'(bcd_valid0), 64'd1);
        check({tag, "_ovf"}, 64'(overflow), 64'(v > 32'd99_999_999));
        check({tag, "_ovf0"}, 64'(overflow0), 64'(v > 32'd99_999_999));
        @(negedge clk);
        check({tag, "_pulse_end"}, 64'(bcd_valid), 64'd0);
    endtask

    // Load, then a second load at a chosen cycle offset; expect only the first to take effect.
    task automatic double_load(input logic [31:0] v1, input logic [31:0] v2, input int at, input string tag);
        int pulses;
        int busy_cyc;
        @(negedge clk);
        count_in = v1;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        pulses   = 0;
        busy_cyc = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == at) begin
                count_in = v2;
                load     = 1'b1;
            end
            if (c == at + 1) load = 1'b0;
            if (busy) busy_cyc++;
            if (bcd_valid) pulses++;
            @(negedge clk);
        end
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_busy_len"}, 64'(busy_cyc), 64'd33);
        check_display(64'(v1), tag);
    endtask

    initial begin
        int pulses;
        int busy_cyc;
        logic [31:0] v;

        vecs[0] = '{32'd1234, 1'b0,
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19},
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{32'd99_999_999, 1'b0, {8{7'h10}}, {8{7'h10}}};
        vecs[2] = '{32'd100_000_000, 1'b1, {8{7'h3F}}, {8{7'h3F}}};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, {8{7'h3F}}, {8{7'h3F}}};
        vecs[4] = '{32'd0, 1'b0, {{7{7'h7F}}, 7'h40}, {8{7'h40}}};
        vecs[5] = '{32'd7, 1'b0, {{7{7'h7F}}, 7'h78}, {{7{7'h40}}, 7'h78}};
        vecs[6] = '{32'd10_000_000, 1'b0, {7'h79, {7{7'h40}}}, {7'h79, {7{7'h40}}}};
        vecs[7] = '{32'd42, 1'b0, {{6{7'h7F}}, 7'h19, 7'h24}, {{6{7'h40}}, 7'h19, 7'h24}};

        // Reset state.
        rst      = 1'b1;
        load     = 1'b0;
        count_in = '0;
        repeat (3) @(negedge clk);
        check("rst_an_n", 64'(an_n), 64'hFE);
        check("rst_seg_n", 64'(seg_n), 64'h40);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(bcd_valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("dp_n", 64'(dp_n), 64'd1);
        rst = 1'b0;
        check_display(64'd0, "after_rst");

        // Table-driven conversions with fixed expectations.
        for (int i = 0; i < 8; i++) begin
            do_convert(vecs[i].value, $sformatf("vec%0d", i));
            scan_capture($sformatf("vec%0d", i));
            check($sformatf("vec%0d_tbl", i), 64'(pack_seen(1'b0)), 64'(vecs[i].segs));
            check($sformatf("vec%0d_tbl0", i), 64'(pack_seen(1'b1)), 64'(vecs[i].segs0));
            check($sformatf("vec%0d_tblovf", i), 64'(overflow), 64'(vecs[i].ovf));
        end

        // A load ten cycles into a conversion is dropped; so is one landing on PUBLISH.
        double_load(32'd5, 32'd7, 9, "load_mid");
        double_load(32'd3, 32'd8, 32, "load_publish");

        // Reset on the 16th shift edge aborts without a pulse and clears the display.
        do_convert(32'd42, "pre_abort");
        check_display(64'd42, "pre_abort");
        @(negedge clk);
        count_in = 32'd900;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        pulses   = 0;
        repeat (15) begin
            @(negedge clk);
            if (bcd_valid) pulses++;
        end
        #2 rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bcd_valid) pulses++;
        end
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ovf", 64'(overflow), 64'd0);
        rst      = 1'b0;
        busy_cyc = 0;
        repeat (40) begin
            @(negedge clk);
            if (bcd_valid) pulses++;
            if (busy) busy_cyc++;
        end
        check("abort_pulses", 64'(pulses), 64'd0);
        check("abort_idle", 64'(busy_cyc), 64'd0);
        check_display(64'd0, "abort_disp");
        do_convert(32'd900, "after_abort");
        check_display(64'd900, "after_abort");

        // Randomised values against the reference model.
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom;
                1:       v = $urandom % 32'd100_000_000;
                default: v = $urandom_range(0, 9999);
            endcase
            do_convert(v, $sformatf("rnd%0d", i));
            check_display(64'(v), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
